// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
//   Buffered UART transmitter. Bytes are accepted into a small FIFO and sent
//   on txd as 8N1 frames (8N2 with STOP_BITS=2). Defining UART_TX_PARITY_EN
//   inserts an even parity bit after the data bits (8E1 / 8E2).
//
// Parameters
//   CLK_PER_BIT     clock cycles per serial bit (>= 2)
//   FIFO_DEPTH_LOG2 log2 of the number of FIFO entries
//   STOP_BITS       1 or 2
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; aborts any frame, flushes FIFO
//   in_data     byte to transmit
//   in_valid    in_data is valid
//   in_ready    FIFO can accept (count below depth)
//   txd         registered serial output, idles high
//   busy        frame in progress or bytes still queued
//   fifo_count  queued bytes, not counting the one being shifted
//   state_dbg   current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: a byte is taken on any rising edge where in_valid && in_ready.
// in_ready depends only on registered count, never on in_valid, so the
// upstream side may hold in_valid/in_data until it sees the transfer.
//
// Timing: txd is a registered copy of the line level implied by the state
// of the previous cycle, so it trails the state register by one clock.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int STOP_BITS       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     txd,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic [2:0]               state_dbg
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0]              BAUD_LAST  = BW'(CLK_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [2:0]                 STOP_LAST  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;

  state_t                     state;
  logic [7:0]                 sh;
  logic [2:0]                 bit_idx;
  logic [BW-1:0]              baud_cnt;
`ifdef UART_TX_PARITY_EN
  logic                       parity_bit;
`endif

  logic       push;
  logic       pop;
  logic       bit_end;
  logic       frame_end;
  logic [7:0] head;

  assign in_ready   = (count != COUNT_FULL);
  assign push       = in_valid && in_ready;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  // The last stop bit finishing; bit_idx counts stop bits while in STOP.
  assign frame_end  = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
  // Pop from IDLE, or chain straight into the next frame with no idle gap.
  assign pop        = (count != '0) && ((state == S_IDLE) || frame_end);
  assign head       = mem[rd_ptr];
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;
  assign state_dbg  = state;

  // FIFO storage: contents need no reset, pointers and count do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A push while full is blocked by in_ready, even if a pop happens.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM with registered txd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sh         <= '0;
      bit_idx    <= '0;
      baud_cnt   <= '0;
      txd        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            sh         <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= S_START;
          end
        end

        S_START: begin
          txd <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          txd <= sh[0];
          if (bit_end) begin
            baud_cnt <= '0;
            sh       <= {1'b0, sh[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          txd <= parity_bit;
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (pop) begin
                sh         <= head;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^head;
`endif
                state      <= S_START;
              end else begin
                state      <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto txd as 8N1 frames (optionally 8E1).
- Sits between core I/O logic (or a test stimulus master) and the board serial line.
- Is the driving end of the line sampled by the design's rxd input; idle line level is 1.

Parameters:
- CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO entries (default 16 entries).
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept; equals !full.
- txd  output  1  serial output, registered.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  FIFO_DEPTH_LOG2+1  number of queued bytes, excluding the byte being shifted.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: txd=1, in_ready=1, busy=0, fifo_count=0, state=IDLE, FIFO pointers=0, bit and baud counters=0.
- Reset asserted mid-frame: the frame is aborted and the FIFO is flushed. txd=1 from the cycle after the reset edge.
- Push: occurs on a rising edge with in_valid && in_ready. in_ready is a pure function of registered count (count < 2^FIFO_DEPTH_LOG2).
- Push when full: no push, even if a pop happens in the same cycle. The next cycle shows in_ready=1.
- Simultaneous push and pop (not full): count is unchanged; data order is preserved.
- Pop: in IDLE with count != 0, pop the head into shift register sh. The state becomes START at the next edge.
- States (bit timer: baud counter counts 0..CLK_PER_BIT-1; each state ends when the counter reaches CLK_PER_BIT-1):
  - IDLE: txd=1.
  - START: txd=0 for CLK_PER_BIT cycles.
  - DATA: 8 bits, LSB first. txd=sh[0]; shift right at each bit end; bit index 0..7. Goes to PARITY if enabled, else STOP.
  - PARITY: optional, see below.
  - STOP: txd=1 for STOP_BITS*CLK_PER_BIT cycles.
  - After STOP: go to START directly if FIFO is non-empty (pop on the same edge), else IDLE. Back-to-back frames therefore have no idle gap.
- Latency: a byte pushed at edge N into an empty FIFO with state IDLE is popped at edge N+1, and txd falls at edge N+2.
- Frame length: (1+8+STOP_BITS)*CLK_PER_BIT cycles, plus CLK_PER_BIT if parity is enabled.
- busy = (state != IDLE) || (count != 0).
- Arithmetic: count uses FIFO_DEPTH_LOG2+1 bits. Pointers use FIFO_DEPTH_LOG2 bits and wrap modulo depth.
- FIFO storage: a register array; no reset of contents is required.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: a PARITY state follows DATA and drives the even parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles. The frame becomes 8E1 (or 8E2).
- When undefined: there is no PARITY state, no parity logic, and the frame is 8N1/8N2.

Test Plan:
- Reset, idle (CLK_PER_BIT=4): hold rst high 10 cycles, then low 20 cycles, in_valid=0 -> txd=1, busy=0, in_ready=1, fifo_count=0 throughout.
- Single byte 0xA5 pushed at edge N (CLK_PER_BIT=4):
  - Without parity: txd falls at edge N+2. Bits sampled mid-bit are 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Frame is 40 cycles; busy=0 afterwards.
  - With UART_TX_PARITY_EN: parity bit = 0; frame is 44 cycles.
- Burst: push 0x00,0xFF,0x55 on consecutive cycles -> three frames with no idle cycle between stop and next start; fifo_count peaks at 2.
- Full FIFO (depth 16): hold in_valid=1 for 20 cycles while the first frame is in flight.
  - in_ready drops after 17 accepted bytes (1 popped plus 16 queued); fifo_count=16.
  - Extra bytes are not accepted; all 17 bytes appear on txd in order.
- Reset mid-frame: assert rst during DATA bit 3 with 5 bytes queued -> txd=1 next cycle, fifo_count=0, and no further frames.
- STOP_BITS=2, byte 0x80: stop high lasts 8 cycles (CLK_PER_BIT=4); total frame is 44 cycles.
